init_sequencer: RTL

INIT_SEQUENCER -- requirements
Module: init_sequencer

---
 rtl/init_sequencer_if.sv | 36 +++
 rtl/init_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/init_sequencer_if.sv
// AXI-lite style master bus used by init_sequencer: write address/data/response and read address/data channels.
// Only the two low response bits are significant; the upper bits are carried for bus compatibility.
interface init_sequencer_if;
   logic [31:0] m_axi_awaddr;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [7:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [7:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   modport master (
      output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
      output m_axi_wdata, m_axi_wvalid, input m_axi_wready,
      input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
      output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
      input m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
   );

   modport slave (
      input m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
      input m_axi_wdata, m_axi_wvalid, output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
      input m_axi_araddr, m_axi_arvalid, output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
   );
endinterface

// File: rtl/init_sequencer.sv
// Table-driven register init sequencer: walks WRITE/POLL/WAIT/END steps over an AXI master bus.
// Define INIT_SEQ_POLL_TIMEOUT_EN to fail a POLL step after MAX_POLLS failed compares.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | latch table entry at idx, branch on op
// WR_REQ    | awvalid/wvalid outstanding until each is accepted
// WR_RESP   | bready high, waiting for write response
// RD_REQ    | arvalid high until accepted
// RD_RESP   | rready high, compare masked read data
// WAIT      | down-counting the delay loaded in FETCH
// FINISH    | one-cycle done pulse
module init_sequencer #(
   parameter int MAX_STEPS = 64,
   parameter int MAX_POLLS = 1024,
   localparam int IW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
   input  logic            s_axi_clk,
   input  logic            s_axi_aresetn,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [IW-1:0]   err_idx,
   output logic [IW-1:0]   tbl_idx,
   input  logic [97:0]     tbl_entry,
   init_sequencer_if.master axi
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_WAIT, S_FINISH
   } state_t;

   localparam logic [1:0] OP_END   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [IW-1:0] LAST_IDX = IW'(MAX_STEPS - 1);

   state_t        state, state_d;
   logic [IW-1:0] idx;
   logic          wrapped;
   logic [31:0]   addr_q, data_q, mask_q;
   logic [15:0]   wait_cnt;
   logic          aw_ok, w_ok, aw_hs, w_hs;
   logic          begin_run, latch_entry, step_adv, step_fail, poll_miss, poll_limit;
   logic [1:0]    op;
   logic          rd_match;

   assign op       = tbl_entry[97:96];
   assign rd_match = ((axi.m_axi_rdata & mask_q) == (data_q & mask_q));

`ifdef INIT_SEQ_POLL_TIMEOUT_EN
   localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;
   logic [PW-1:0] poll_cnt;
   logic          unused_cfg;

   assign poll_limit = (poll_cnt == PW'(MAX_POLLS - 1));
   assign unused_cfg = ^{axi.m_axi_bresp[7:2], axi.m_axi_rresp[7:2]};

   always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn)    poll_cnt <= '0;
      else if (latch_entry)  poll_cnt <= '0;
      else if (poll_miss)    poll_cnt <= poll_cnt + 1'b1;
   end
`else
   logic unused_cfg;

   assign poll_limit = 1'b0;
   assign unused_cfg = ^{32'(MAX_POLLS), poll_miss, axi.m_axi_bresp[7:2], axi.m_axi_rresp[7:2]};
`endif

   assign axi.m_axi_awaddr  = addr_q;
   assign axi.m_axi_wdata   = data_q;
   assign axi.m_axi_araddr  = addr_q;
   assign axi.m_axi_awvalid = (state == S_WR_REQ) && !aw_ok;
   assign axi.m_axi_wvalid  = (state == S_WR_REQ) && !w_ok;
   assign axi.m_axi_bready  = (state == S_WR_RESP);
   assign axi.m_axi_arvalid = (state == S_RD_REQ);
   assign axi.m_axi_rready  = (state == S_RD_RESP);
   assign aw_hs             = axi.m_axi_awvalid && axi.m_axi_awready;
   assign w_hs              = axi.m_axi_wvalid && axi.m_axi_wready;

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_FINISH);
   assign tbl_idx = idx;

   always_comb begin
      state_d     = state;
      begin_run   = 1'b0;
      latch_entry = 1'b0;
      step_adv    = 1'b0;
      step_fail   = 1'b0;
      poll_miss   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               begin_run = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            latch_entry = 1'b1;
            if (wrapped || op == OP_END) state_d = S_FINISH;
            else if (op == OP_WRITE)     state_d = S_WR_REQ;
            else if (op == OP_POLL)      state_d = S_RD_REQ;
            else                         state_d = S_WAIT;
         end
         S_WR_REQ: begin
            if ((aw_ok || aw_hs) && (w_ok || w_hs)) state_d = S_WR_RESP;
         end
         S_WR_RESP: begin
            if (axi.m_axi_bvalid) begin
               if (axi.m_axi_bresp[1:0] != 2'b00) begin
                  step_fail = 1'b1;
                  state_d   = S_FINISH;
               end else begin
                  step_adv = 1'b1;
                  state_d  = S_FETCH;
               end
            end
         end
         S_RD_REQ: begin
            if (axi.m_axi_arready) state_d = S_RD_RESP;
         end
         S_RD_RESP: begin
            if (axi.m_axi_rvalid) begin
               if (axi.m_axi_rresp[1:0] != 2'b00 || (!rd_match && poll_limit)) begin
                  step_fail = 1'b1;
                  state_d   = S_FINISH;
               end else if (rd_match) begin
                  step_adv = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  poll_miss = 1'b1;
                  state_d   = S_RD_REQ;
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt == 16'd0) begin
               step_adv = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state    <= S_IDLE;
         idx      <= '0;
         wrapped  <= 1'b0;
         error    <= 1'b0;
         err_idx  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         mask_q   <= '0;
         wait_cnt <= '0;
         aw_ok    <= 1'b0;
         w_ok     <= 1'b0;
      end else begin
         state <= state_d;
         if (begin_run) begin
            idx     <= '0;
            wrapped <= 1'b0;
            error   <= 1'b0;
            err_idx <= '0;
         end
         if (latch_entry) begin
            addr_q   <= tbl_entry[95:64];
            data_q   <= tbl_entry[63:32];
            mask_q   <= tbl_entry[31:0];
            wait_cnt <= tbl_entry[47:32];
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
         end else begin
            if (aw_hs) aw_ok <= 1'b1;
            if (w_hs)  w_ok  <= 1'b1;
            if (state == S_WAIT && wait_cnt != 16'd0) wait_cnt <= wait_cnt - 16'd1;
         end
         // Completing the last table slot ends the run at the next FETCH.
         if (step_adv) begin
            if (idx == LAST_IDX) begin
               idx     <= '0;
               wrapped <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (step_fail) begin
            error   <= 1'b1;
            err_idx <= idx;
         end
      end
   end

endmodule
